// File: rtl/wb8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb8_pkg
//  Purpose  : Shared types and constants for the 8-bit Wishbone initiator
//             (state encoding, data width, default timeout length).
//  Revision : 1.0  initial release
// ============================================================================
package wb8_pkg;

   localparam int WB8_DATA_WIDTH             = 8;
   localparam int WB8_DEFAULT_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wb8_state_t;

endpackage
`default_nettype wire

// File: rtl/wb8_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : wb8_timeout
//  Purpose  : Clear/enable cycle counter for the Wishbone initiator. The
//             expired flag rises once the count reaches TIMEOUT_CYCLES-1, so
//             a strobe that started at the clear point is aborted after
//             exactly TIMEOUT_CYCLES bus cycles.
//  Revision : 1.0  initial release
// ============================================================================
module wb8_timeout
   import wb8_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = WB8_DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = (cnt_q == LAST_CNT);

   // Next count: clear wins, then count up, saturating at the last value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb8_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb8_master
//  Purpose  : Wishbone classic-cycle initiator for byte-wide responders.
//             One valid/ready request in, one bus cycle, one valid/ready
//             response out.
//  Options  : WB8_MASTER_TIMEOUT_EN - when defined, a bus cycle without ack
//             is aborted after TIMEOUT_CYCLES strobe cycles with rsp_err=1.
//  Revision : 1.0  initial release
// ============================================================================
module wb8_master
   import wb8_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = WB8_DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      I_wb_clk,
   input  logic                      I_reset,
   input  logic                      I_req_valid,
   output logic                      O_req_ready,
   input  logic                      I_req_we,
   input  logic [ADDR_WIDTH-1:0]     I_req_adr,
   input  logic [WB8_DATA_WIDTH-1:0] I_req_dat,
   output logic                      O_rsp_valid,
   input  logic                      I_rsp_ready,
   output logic [WB8_DATA_WIDTH-1:0] O_rsp_dat,
   output logic                      O_rsp_err,
   output logic                      O_wb_cyc,
   output logic                      O_wb_stb,
   output logic                      O_wb_we,
   output logic [ADDR_WIDTH-1:0]     O_wb_adr,
   output logic [WB8_DATA_WIDTH-1:0] O_wb_dat,
   input  logic [WB8_DATA_WIDTH-1:0] I_wb_dat,
   input  logic                      I_wb_ack
);

   wb8_state_t                state_q,     state_d;
   logic                      cyc_q,       cyc_d;
   logic                      we_q,        we_d;
   logic [ADDR_WIDTH-1:0]     adr_q,       adr_d;
   logic [WB8_DATA_WIDTH-1:0] dat_q,       dat_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [WB8_DATA_WIDTH-1:0] rsp_dat_q,   rsp_dat_d;
   logic                      rsp_err_q,   rsp_err_d;
   logic                      bus_expired;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("wb8_master: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef WB8_MASTER_TIMEOUT_EN
   // Counter is held clear outside BUS so every cycle starts from zero.
   wb8_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (I_wb_clk),
      .rst     (I_reset),
      .clr     (state_q != ST_BUS),
      .en      ((state_q == ST_BUS) && !I_wb_ack),
      .expired (bus_expired)
   );
`else
   assign bus_expired = 1'b0;
`endif

   assign O_req_ready = (state_q == ST_IDLE);
   assign O_rsp_valid = rsp_valid_q;
   assign O_rsp_dat   = rsp_dat_q;
   assign O_rsp_err   = rsp_err_q;
   assign O_wb_cyc    = cyc_q;
   assign O_wb_stb    = cyc_q;
   assign O_wb_we     = we_q;
   assign O_wb_adr    = adr_q;
   assign O_wb_dat    = dat_q;

   // Next-state and output decode; ack only matters while in BUS, and ack
   // beats a simultaneous timeout.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (I_req_valid) begin
               we_d    = I_req_we;
               adr_d   = I_req_adr;
               dat_d   = I_req_dat;
               cyc_d   = 1'b1;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            if (I_wb_ack || bus_expired) begin
               rsp_dat_d   = (I_wb_ack && !we_q) ? I_wb_dat : '0;
               rsp_err_d   = !I_wb_ack;
               rsp_valid_d = 1'b1;
               cyc_d       = 1'b0;
               we_d        = 1'b0;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (I_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops the bus cycle immediately.
   always_ff @(posedge I_wb_clk or posedge I_reset) begin
      if (I_reset) begin
         state_q     <= ST_IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb8_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb8_master
//  Purpose  : Self-checking bench for wb8_master with a byte-wide responder
//             that registers ack after a programmable number of wait states.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb8_master;

   localparam int AW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_adr;
   logic [7:0]    req_dat;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [7:0]    rsp_dat;
   logic          wb_cyc, wb_stb, wb_we, wb_ack;
   logic [AW-1:0] wb_adr;
   logic [7:0]    wb_odat, wb_idat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb8_master #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .I_wb_clk    (clk),
      .I_reset     (rst),
      .I_req_valid (req_valid),
      .O_req_ready (req_ready),
      .I_req_we    (req_we),
      .I_req_adr   (req_adr),
      .I_req_dat   (req_dat),
      .O_rsp_valid (rsp_valid),
      .I_rsp_ready (rsp_ready),
      .O_rsp_dat   (rsp_dat),
      .O_rsp_err   (rsp_err),
      .O_wb_cyc    (wb_cyc),
      .O_wb_stb    (wb_stb),
      .O_wb_we     (wb_we),
      .O_wb_adr    (wb_adr),
      .O_wb_dat    (wb_odat),
      .I_wb_dat    (wb_idat),
      .I_wb_ack    (wb_ack)
   );

   // Responder: register file, ack raised after wait_cfg extra cycles.
   logic [7:0] mem [0:255];
   logic       resp_ack;
   logic       force_ack;
   int         wait_cfg;
   bit         noack;
   int         wcnt;

   assign wb_ack  = resp_ack | force_ack;
   assign wb_idat = mem[wb_adr];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_ack <= 1'b0;
         wcnt     <= 0;
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (wb_cyc && wb_stb && !resp_ack && !noack) begin
         if (wcnt >= wait_cfg) begin
            resp_ack <= 1'b1;
            wcnt     <= 0;
            if (wb_we) mem[wb_adr] <= wb_odat;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         resp_ack <= 1'b0;
         wcnt     <= 0;
      end
   end

   // Behavioural memory image used to predict read data.
   logic [7:0] ref_mem [0:255];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One full request/bus/response transaction with checks at every stage.
   task automatic run_txn(input string tag, input logic we, input logic [7:0] adr,
                          input logic [7:0] dat, input int wait_n, input bit no_ack,
                          input int rsp_delay, input logic [7:0] exp_dat,
                          input logic exp_err, input int exp_stb);
      int n;
      wait_cfg = wait_n;
      noack    = no_ack;
      @(negedge clk);
      check($sformatf("%s req_ready_idle", tag), 32'(req_ready), 1);
      req_valid = 1'b1;
      req_we    = we;
      req_adr   = adr;
      req_dat   = dat;
      rsp_ready = (rsp_delay == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check($sformatf("%s cyc_start", tag), 32'(wb_cyc), 1);
      check($sformatf("%s stb_start", tag), 32'(wb_stb), 1);
      check($sformatf("%s we_bus", tag), 32'(wb_we), 32'(we));
      check($sformatf("%s adr_bus", tag), 32'(wb_adr), 32'(adr));
      if (we) check($sformatf("%s dat_bus", tag), 32'(wb_odat), 32'(dat));
      check($sformatf("%s req_ready_bus", tag), 32'(req_ready), 0);
      n = 0;
      do begin
         n++;
         @(posedge clk); #1;
      end while (wb_stb && n < 200);
      check($sformatf("%s stb_cycles", tag), 32'(n), 32'(exp_stb));
      check($sformatf("%s cyc_end", tag), 32'(wb_cyc), 0);
      check($sformatf("%s we_end", tag), 32'(wb_we), 0);
      check($sformatf("%s rsp_valid", tag), 32'(rsp_valid), 1);
      check($sformatf("%s rsp_dat", tag), 32'(rsp_dat), 32'(exp_dat));
      check($sformatf("%s rsp_err", tag), 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < rsp_delay; i++) begin
         @(negedge clk);
         force_ack = (i == 1);
         @(posedge clk); #1;
         check($sformatf("%s hold_valid", tag), 32'(rsp_valid), 1);
         check($sformatf("%s hold_dat", tag), 32'(rsp_dat), 32'(exp_dat));
         check($sformatf("%s hold_err", tag), 32'(rsp_err), 32'(exp_err));
         check($sformatf("%s hold_req_ready", tag), 32'(req_ready), 0);
         check($sformatf("%s hold_stb", tag), 32'(wb_stb), 0);
      end
      @(negedge clk);
      force_ack = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s rsp_done", tag), 32'(rsp_valid), 0);
      check($sformatf("%s req_ready_back", tag), 32'(req_ready), 1);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic       we;
      logic [7:0] adr;
      logic [7:0] dat;
      int         wait_n;
      int         rsp_delay;
      logic [7:0] exp_dat;
      int         exp_stb;
   } vec_t;

   initial begin
      vec_t vecs [8];
      logic       r_we;
      logic [7:0] r_adr, r_dat, r_exp;
      int         r_wait, r_delay, r_stb;
      bit         r_noack;

      vecs[0] = '{1'b1, 8'h00, 8'hA5, 0, 0, 8'h00, 2};
      vecs[1] = '{1'b0, 8'h00, 8'h00, 0, 5, 8'hA5, 2};
      vecs[2] = '{1'b1, 8'h10, 8'h3C, 1, 1, 8'h00, 3};
      vecs[3] = '{1'b0, 8'h10, 8'hFF, 0, 0, 8'h3C, 2};
      vecs[4] = '{1'b1, 8'hFF, 8'h5A, 3, 2, 8'h00, 5};
      vecs[5] = '{1'b0, 8'hFF, 8'h00, 2, 0, 8'h5A, 4};
      vecs[6] = '{1'b0, 8'h00, 8'h00, 0, 1, 8'hA5, 2};
      vecs[7] = '{1'b0, 8'h42, 8'h00, 0, 0, 8'h00, 2};

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
      rsp_ready = 1'b0; force_ack = 1'b0; wait_cfg = 0; noack = 1'b0;

      #1;
      check("reset req_ready", 32'(req_ready), 1);
      check("reset cyc", 32'(wb_cyc), 0);
      check("reset stb", 32'(wb_stb), 0);
      check("reset we", 32'(wb_we), 0);
      check("reset adr", 32'(wb_adr), 0);
      check("reset wdat", 32'(wb_odat), 0);
      check("reset rsp_valid", 32'(rsp_valid), 0);
      check("reset rsp_dat", 32'(rsp_dat), 0);
      check("reset rsp_err", 32'(rsp_err), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Spurious acks while idle must not produce a response.
      @(negedge clk);
      force_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("idle_ack rsp_valid", 32'(rsp_valid), 0);
         check("idle_ack cyc", 32'(wb_cyc), 0);
         check("idle_ack req_ready", 32'(req_ready), 1);
      end
      @(negedge clk);
      force_ack = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat,
                 vecs[i].wait_n, 1'b0, vecs[i].rsp_delay, vecs[i].exp_dat, 1'b0,
                 vecs[i].exp_stb);
         if (vecs[i].we) ref_mem[vecs[i].adr] = vecs[i].dat;
      end
      check("responder reg 00", 32'(mem[8'h00]), 32'h A5);

`ifdef WB8_MASTER_TIMEOUT_EN
      run_txn("timeout_noack", 1'b0, 8'h10, 8'h00, 0, 1'b1, 2, 8'h00, 1'b1, TO);
      run_txn("timeout_ack_last", 1'b1, 8'h21, 8'h77, TO - 2, 1'b0, 0, 8'h00, 1'b0, TO);
      ref_mem[8'h21] = 8'h77;
      run_txn("timeout_readback", 1'b0, 8'h21, 8'h00, 0, 1'b0, 0, 8'h77, 1'b0, 2);
`endif

      // Randomized traffic against the memory-image model.
      for (int t = 0; t < 40; t++) begin
         r_we    = 1'($urandom % 2);
         r_adr   = 8'($urandom);
         r_dat   = 8'($urandom);
         r_wait  = int'($urandom % 4);
         r_delay = int'($urandom % 4);
         r_noack = 1'b0;
`ifdef WB8_MASTER_TIMEOUT_EN
         case ($urandom % 6)
            4:       r_wait  = TO - 2;
            5:       r_noack = 1'b1;
            default: ;
         endcase
`endif
         r_stb = r_noack ? TO : r_wait + 2;
         r_exp = (r_we || r_noack) ? 8'h00 : ref_mem[r_adr];
         run_txn($sformatf("rand%0d", t), r_we, r_adr, r_dat, r_wait, r_noack,
                 r_delay, r_exp, r_noack, r_stb);
         if (r_we && !r_noack) ref_mem[r_adr] = r_dat;
      end

      // Reset in the middle of a bus cycle drops everything asynchronously.
      noack = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h33;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("midbus stb_before", 32'(wb_stb), 1);
      #2;
      rst = 1'b1;
      #1;
      check("midbus cyc_async", 32'(wb_cyc), 0);
      check("midbus stb_async", 32'(wb_stb), 0);
      check("midbus rsp_valid_async", 32'(rsp_valid), 0);
      check("midbus req_ready_async", 32'(req_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      noack = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post_reset rsp_valid", 32'(rsp_valid), 0);
         check("post_reset req_ready", 32'(req_ready), 1);
      end
      rsp_ready = 1'b0;
      run_txn("post_reset_wr", 1'b1, 8'h33, 8'hC3, 0, 1'b0, 0, 8'h00, 1'b0, 2);
      run_txn("post_reset_rd", 1'b0, 8'h33, 8'h00, 1, 1'b0, 1, 8'hC3, 1'b0, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/wb8_master.md
# wb8_master

Wishbone classic-cycle initiator for the 8-bit peripheral bus. It accepts single read/write requests on a valid/ready command port, runs one Wishbone cycle per request against byte-wide responders such as the LED and GPIO peripherals, and returns read data and status on a valid/ready response port. It is the bus-side engine for the debug/loader bridge, and it can also stand in for the CPU in peripheral testbenches.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of O_wb_adr and I_req_adr.
- TIMEOUT_CYCLES, 16, number of cycles stb may stay high without ack before the cycle is aborted (only with WB8_MASTER_TIMEOUT_EN; minimum 2).

Ports (one clock; reset is asynchronous and active-high):
- I_wb_clk  in  1  bus clock; all logic on rising edge.
- I_reset  in  1  async active-high reset.
- I_req_valid  in  1  request present.
- O_req_ready  out  1  request accepted when valid && ready.
- I_req_we  in  1  1 = write, 0 = read.
- I_req_adr  in  ADDR_WIDTH  target address.
- I_req_dat  in  8  write data.
- O_rsp_valid  out  1  response present.
- I_rsp_ready  in  1  response consumed when valid && ready.
- O_rsp_dat  out  8  read data (0x00 for writes and errors).
- O_rsp_err  out  1  1 = cycle timed out.
- O_wb_cyc, O_wb_stb, O_wb_we  out  1 each  Wishbone control.
- O_wb_adr  out  ADDR_WIDTH  address.
- O_wb_dat  out  8  write data.
- I_wb_dat  in  8  read data.
- I_wb_ack  in  1  responder acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: O_req_ready=1. On valid && ready, latch we/adr/dat into O_wb_we/O_wb_adr/O_wb_dat, set cyc=stb=1, go to BUS.
- BUS: O_req_ready=0. cyc, stb, adr, we and dat are stable. When I_wb_ack is sampled high, capture I_wb_dat into O_rsp_dat (reads only; writes load 0x00), clear cyc/stb/we, set O_rsp_valid=1 and O_rsp_err=0, go to RESP.
- RESP: hold O_rsp_* stable until I_rsp_ready. On the handshake edge, clear O_rsp_valid and go to IDLE. I_rsp_ready may be high in advance.
- I_wb_ack is ignored outside BUS. Responders that register ack from stb leave a trailing ack pulse in RESP, and it must be harmless.
- O_wb_adr and O_wb_dat retain their last values after a cycle. This is not a requirement, but checkers must not rely on them being cleared.
- Reset: state IDLE; every output is 0 except O_req_ready, which is 1 after reset. A reset during BUS or RESP aborts the transaction with no response and drops cyc/stb immediately, asynchronously.

## Timing
- Request accepted at edge E0. stb is high from E0 to the edge at which ack is sampled.
- With a responder that registers ack one cycle after stb, ack is sampled at E2 and O_rsp_valid is high after E2. That gives 2 cycles request-to-response.
- Minimum spacing: with I_rsp_ready held high, the next request is accepted at E4. stb is therefore low for at least 1 cycle between cycles.
- Timeout counter: cleared on entry to BUS and incremented each BUS cycle without ack. When it reaches TIMEOUT_CYCLES-1 with no ack, the cycle aborts exactly like an ack, with O_rsp_err=1 and O_rsp_dat=0x00. stb is high for exactly TIMEOUT_CYCLES cycles.
- If ack and the timeout occur in the same cycle, ack wins (err=0, data captured).

## Configuration
- WB8_MASTER_TIMEOUT_EN defined: timeout counter and abort path present as above.
- WB8_MASTER_TIMEOUT_EN undefined: no counter. BUS waits for ack indefinitely and O_rsp_err is tied to 0. TIMEOUT_CYCLES is unused.

## Structure
- Shared package wb8_pkg holds:
  - FSM state encoding (IDLE/BUS/RESP)
  - data width constant 8
  - default TIMEOUT_CYCLES
- One sub-module, wb8_timeout: a clear/enable counter with an expired flag, sized $clog2(TIMEOUT_CYCLES). It is instantiated only under WB8_MASTER_TIMEOUT_EN.

## Test plan
- Write: req we=1, adr=0x00, dat=0xA5 against a LED-style responder (registered ack) -> stb high 2 cycles, rsp_valid at E2, err=0, rsp_dat=0x00, responder register holds 0xA5.
- Read: responder returns 0x3C -> rsp_dat=0x3C one cycle after ack sampled, cyc/stb low the same edge.
- Backpressure: I_rsp_ready low 5 cycles -> rsp_valid/dat/err stable, O_req_ready=0 throughout, trailing ack ignored; IDLE one edge after ready.
- Timeout (macro on, TIMEOUT_CYCLES=16): no-ack responder -> stb high exactly 16 cycles, then rsp_valid=1, err=1, dat=0x00. Repeat with ack in cycle 16 -> err=0.
- Reset asserted mid-BUS -> cyc/stb/rsp_valid drop without waiting for a clock edge; after release, O_req_ready=1 and no stale response appears.
- Spurious I_wb_ack pulses while IDLE -> no rsp_valid, no state change.
